fetch_queue: RTL

Dual-issue instruction fetch queue at the front of `cpu_top`, on the receiving end of the two-instructions-per-cycle fetch stream (`instruction_1`, `instruction_2`). It buffers the fetched words in a circular FIFO and hands zero, one or two instructions per cycle, in program order, to decode/rename. Its `in_ready` back-pressures fetch, so fetch stalls instead of dropping instructions.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/fetch_queue.sv | 121 ++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared cpu types and constants
package cpu_pkg;
    localparam int INSTR_W = 32;
    localparam int FETCH_W = 2;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [31:0]        pc_t;
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - dual-issue instruction fetch queue (optional PC tracking: FETCH_QUEUE_PC_EN)
module fetch_queue #(
    parameter int DEPTH   = 8,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid_1,
    input  logic                     in_valid_2,
    input  logic [INSTR_W-1:0]       instruction_1,
    input  logic [INSTR_W-1:0]       instruction_2,
    output logic                     in_ready,
    output logic                     out_valid_1,
    output logic                     out_valid_2,
    output logic [INSTR_W-1:0]       out_instruction_1,
    output logic [INSTR_W-1:0]       out_instruction_2,
    input  logic [1:0]               dec_take,
`ifdef FETCH_QUEUE_PC_EN
    output cpu_pkg::pc_t             out_pc_1,
    output cpu_pkg::pc_t             out_pc_2,
`endif
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      head_q, head_d;
    logic [AW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic [AW-1:0]      head_nxt;
    logic [1:0]         take_req;
    logic [CW-1:0]      take;
    logic [CW-1:0]      push_n;
    logic               push_1;
    logic               push_2;

    // Space check uses the current count only, so a pair always fits when accepted
    assign in_ready    = (count_q <= CW'(DEPTH - 2));
    assign out_valid_1 = (count_q >= CW'(1));
    assign out_valid_2 = (count_q >= CW'(2));
    assign head_nxt    = head_q + AW'(1);
    assign out_instruction_1 = mem_q[head_q];
    assign out_instruction_2 = mem_q[head_nxt];
    assign count       = count_q;

    // Next-state pointers and occupancy; pop is clamped to what is actually held
    always_comb begin
        take_req = (dec_take == 2'd3) ? 2'd2 : dec_take;
        take     = (CW'(take_req) > count_q) ? count_q : CW'(take_req);
        push_1   = in_ready && in_valid_1;
        push_2   = push_1 && in_valid_2;
        push_n   = push_2 ? CW'(2) : (push_1 ? CW'(1) : CW'(0));
        head_d   = head_q + AW'(take);
        tail_d   = tail_q + AW'(push_n);
        count_d  = count_q + push_n - take;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer/count registers and entry storage; reset also clears storage
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (!flush && push_1) begin
                mem_q[tail_q] <= instruction_1;
            end
            if (!flush && push_2) begin
                mem_q[tail_q + AW'(1)] <= instruction_2;
            end
        end
    end

`ifdef FETCH_QUEUE_PC_EN
    cpu_pkg::pc_t pc_mem_q [DEPTH];
    cpu_pkg::pc_t pc_q, pc_d;

    assign out_pc_1 = pc_mem_q[head_q];
    assign out_pc_2 = pc_mem_q[head_nxt];

    // Fetch PC advances one word per accepted instruction and restarts at 0 on redirect
    always_comb begin
        pc_d = pc_q + {{(32-CW-2){1'b0}}, push_n, 2'b00};
        if (flush) begin
            pc_d = '0;
        end
    end

    // PC register and per-entry PC storage, written alongside the instruction words
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i] <= '0;
            end
        end else begin
            pc_q <= pc_d;
            if (!flush && push_1) begin
                pc_mem_q[tail_q] <= pc_q;
            end
            if (!flush && push_2) begin
                pc_mem_q[tail_q + AW'(1)] <= pc_q + 32'd4;
            end
        end
    end
`endif

endmodule
